target_pos_gen: RTL
===================

# target_pos_gen

Parametrised food-target placer for the snake game, the successor to the fixed 8/7-bit LFSR target generator. Two free-running Galois LFSRs of configurable width supply candidate coordinates. A request/valid FSM rejection-samples them against the playfield bounds and against snake-body occupancy through a query handshake. After a bounded number of failed draws it falls back to the screen centre. The block sits between the game-control FSM (which raises REQ when the target is eaten) and the VGA/target-drawing logic.

## Interface
Parameters:
- H_WIDTH, 8, horizontal coordinate / LFSR width
- V_WIDTH, 7, vertical coordinate / LFSR width
- H_MAX, 160, horizontal bound; legal H is 0..H_MAX-1; H_MAX ≤ 2^H_WIDTH
- V_MAX, 120, vertical bound; legal V is 0..V_MAX-1; V_MAX ≤ 2^V_WIDTH
- H_TAPS, 8'hB8, Galois feedback mask for the H LFSR
- V_TAPS, 7'h60, Galois feedback mask for the V LFSR
- H_SEED, 8'h08, nonzero reset seed for H
- V_SEED, 7'h08, nonzero reset seed for V
- MAX_TRIES, 16, rejected draws allowed before fallback

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- REQ  in  1  request a new target; sampled only in IDLE
- SEED_LOAD  in  1  load SEED_H/SEED_V into the LFSRs
- SEED_H  in  H_WIDTH  H seed; 0 means use H_SEED
- SEED_V  in  V_WIDTH  V seed; 0 means use V_SEED
- OCC_REQ  out  1  occupancy query valid; held until OCC_ACK
- OCC_ADDR_H  out  H_WIDTH  queried H coordinate
- OCC_ADDR_V  out  V_WIDTH  queried V coordinate
- OCC_ACK  in  1  query answered this cycle
- OCC_HIT  in  1  queried cell is occupied; qualified by OCC_ACK
- BUSY  out  1  FSM is not in IDLE
- VALID  out  1  one-cycle pulse; new target committed
- FALLBACK  out  1  last committed target is the fallback centre
- TARGET_ADDR_H  out  H_WIDTH  current target H coordinate
- TARGET_ADDR_V  out  V_WIDTH  current target V coordinate

## Operation
- LFSRs: right-shift Galois. If lsb = 1, the next value is (s>>1)^TAPS; otherwise it is s>>1. Both advance every cycle, independent of FSM state.
- SEED_LOAD: that edge loads the seeds instead of advancing. A zero seed is substituted by the parameter seed, so the all-zero lock-up state is unreachable.
- FSM states and transitions:
  - IDLE: on REQ, clear the try counter and go to DRAW.
  - DRAW: each cycle, sample the current LFSR values (h, v).
    - If h < H_MAX and v < V_MAX: latch (h, v) into OCC_ADDR, go to CHECK.
    - Otherwise: increment tries. If tries reaches MAX_TRIES, go to FALLBK; else stay in DRAW.
  - CHECK: OCC_REQ = 1 with stable addresses.
    - On OCC_ACK with !OCC_HIT: go to DONE, accepting OCC_ADDR.
    - On OCC_ACK with OCC_HIT: increment tries, then go to FALLBK if tries reaches MAX_TRIES, else to DRAW.
  - FALLBK: select (H_MAX/2, V_MAX/2) without an occupancy check, then go to DONE.
  - DONE: the TARGET registers update, VALID = 1 and FALLBACK is updated, all on the same edge. Go to IDLE.
- Both range rejections and occupancy hits count toward MAX_TRIES. The try counter is clog2(MAX_TRIES+1) bits wide.
- All comparisons are unsigned, at the native widths.

## Timing
- Reset values:
  - TARGET_ADDR_H = H_MAX/2 (80), TARGET_ADDR_V = V_MAX/2 (60)
  - VALID, BUSY, OCC_REQ, FALLBACK = 0
  - OCC_ADDR = 0; LFSRs = H_SEED/V_SEED; state = IDLE
- Minimum latency: REQ at cycle 0 → DRAW at 1 → OCC_REQ at 2 (an ACK may arrive in the same cycle) → VALID at 3.
- Each rejected draw adds 1 cycle. Each occupancy round-trip adds its ACK delay plus 1 cycle.
- REQ while BUSY is ignored and is not queued.
- OCC_ACK outside CHECK is ignored. OCC_HIT is only meaningful when OCC_ACK is high.
- Reset mid-operation: return to IDLE and drop OCC_REQ in the same edge. The TARGET outputs return to their reset values.
- SEED_LOAD and REQ in the same cycle: the first DRAW samples the loaded seeds.
- RESET takes priority over SEED_LOAD, and SEED_LOAD takes priority over LFSR advance.

## Structure
- Shared package snake_pkg holds:
  - the FSM state enum (IDLE, DRAW, CHECK, FALLBK, DONE)
  - the default screen constants (160×120) and default taps and seeds
- One sub-module, lfsr_galois, parametrised by WIDTH, TAPS and SEED, with inputs load and load_val. It is instantiated once per axis.

## Test plan
- Reset: after RESET, TARGET = (80, 60), VALID/BUSY/OCC_REQ/FALLBACK = 0.
- Accept path: SEED_LOAD with H = 1, V = 1 together with REQ; OCC_ACK = 1 and OCC_HIT = 0 tied → OCC_ADDR = (1, 1) at cycle 2, VALID at cycle 3, TARGET = (1, 1), FALLBACK = 0.
- Range rejection: SEED_LOAD with H = 8'hB8, V = 1 together with REQ; ACK tied high, no hit → draw (184, 1) is rejected, next draw (92, 96) is accepted, VALID at cycle 4.
- Occupancy retry and fallback: OCC_HIT = 1 on every ACK → after 16 counted failures, TARGET = (80, 60), FALLBACK = 1, VALID pulses once.
- Handshake hold: ACK delayed 5 cycles → OCC_REQ and OCC_ADDR stay stable throughout; REQ pulses while BUSY are ignored, giving exactly one VALID.
- Zero seed and mid-op reset: SEED_LOAD with 0/0 → LFSRs read 8'h08/7'h08. Assert RESET while in CHECK → next cycle OCC_REQ = 0, BUSY = 0, TARGET = (80, 60).

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: target FSM states, default playfield
// geometry and the default LFSR taps/seeds for the target generator.
package snake_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAW   = 3'd1,
      ST_CHECK  = 3'd2,
      ST_FALLBK = 3'd3,
      ST_DONE   = 3'd4
   } tpg_state_e;

   localparam int SCREEN_H = 160;
   localparam int SCREEN_V = 120;

   localparam logic [7:0] DEF_H_TAPS = 8'hB8;
   localparam logic [6:0] DEF_V_TAPS = 7'h60;
   localparam logic [7:0] DEF_H_SEED = 8'h08;
   localparam logic [6:0] DEF_V_SEED = 7'h08;

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR with a synchronous seed load.
// A zero load value is replaced by SEED so the all-zero lock-up state is never entered.
module lfsr_galois #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = '1,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge CLK) begin
      if (RESET)
         value <= SEED;
      else if (load)
         value <= (load_val == '0) ? SEED : load_val;
      else if (value[0])
         value <= (value >> 1) ^ TAPS;
      else
         value <= value >> 1;
   end

endmodule

// File: rtl/target_pos_gen.sv
// Food-target placer: rejection-samples LFSR coordinates against the playfield and
// the snake body (via the OCC query), falling back to the screen centre after MAX_TRIES.
module target_pos_gen
   import snake_pkg::*;
#(
   parameter int                 H_WIDTH   = 8,
   parameter int                 V_WIDTH   = 7,
   parameter int                 H_MAX     = SCREEN_H,
   parameter int                 V_MAX     = SCREEN_V,
   parameter logic [H_WIDTH-1:0] H_TAPS    = DEF_H_TAPS,
   parameter logic [V_WIDTH-1:0] V_TAPS    = DEF_V_TAPS,
   parameter logic [H_WIDTH-1:0] H_SEED    = DEF_H_SEED,
   parameter logic [V_WIDTH-1:0] V_SEED    = DEF_V_SEED,
   parameter int                 MAX_TRIES = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               REQ,
   input  logic               SEED_LOAD,
   input  logic [H_WIDTH-1:0] SEED_H,
   input  logic [V_WIDTH-1:0] SEED_V,
   output logic               OCC_REQ,
   output logic [H_WIDTH-1:0] OCC_ADDR_H,
   output logic [V_WIDTH-1:0] OCC_ADDR_V,
   input  logic               OCC_ACK,
   input  logic               OCC_HIT,
   output logic               BUSY,
   output logic               VALID,
   output logic               FALLBACK,
   output logic [H_WIDTH-1:0] TARGET_ADDR_H,
   output logic [V_WIDTH-1:0] TARGET_ADDR_V
);

   localparam int                 TRY_W    = $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0]   TRY_LAST = TRY_W'(MAX_TRIES - 1);
   localparam logic [H_WIDTH-1:0] CTR_H    = H_WIDTH'(H_MAX / 2);
   localparam logic [V_WIDTH-1:0] CTR_V    = V_WIDTH'(V_MAX / 2);
   // One extra bit so a bound equal to 2^WIDTH is still representable.
   localparam logic [H_WIDTH:0]   H_LIM    = (H_WIDTH + 1)'(H_MAX);
   localparam logic [V_WIDTH:0]   V_LIM    = (V_WIDTH + 1)'(V_MAX);

   tpg_state_e         state;
   logic [TRY_W-1:0]   tries;
   logic [H_WIDTH-1:0] lfsr_h;
   logic [V_WIDTH-1:0] lfsr_v;
   logic               in_range;
   logic               last_try;

   lfsr_galois #(.WIDTH(H_WIDTH), .TAPS(H_TAPS), .SEED(H_SEED)) u_lfsr_h (
      .CLK      (CLK),
      .RESET    (RESET),
      .load     (SEED_LOAD),
      .load_val (SEED_H),
      .value    (lfsr_h)
   );

   lfsr_galois #(.WIDTH(V_WIDTH), .TAPS(V_TAPS), .SEED(V_SEED)) u_lfsr_v (
      .CLK      (CLK),
      .RESET    (RESET),
      .load     (SEED_LOAD),
      .load_val (SEED_V),
      .value    (lfsr_v)
   );

   assign in_range = ({1'b0, lfsr_h} < H_LIM) && ({1'b0, lfsr_v} < V_LIM);
   assign last_try = (tries == TRY_LAST);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state         <= ST_IDLE;
         tries         <= '0;
         OCC_ADDR_H    <= '0;
         OCC_ADDR_V    <= '0;
         TARGET_ADDR_H <= CTR_H;
         TARGET_ADDR_V <= CTR_V;
         VALID         <= 1'b0;
         FALLBACK      <= 1'b0;
      end else begin
         VALID <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (REQ) begin
                  tries <= '0;
                  state <= ST_DRAW;
               end
            end
            ST_DRAW: begin
               if (in_range) begin
                  OCC_ADDR_H <= lfsr_h;
                  OCC_ADDR_V <= lfsr_v;
                  state      <= ST_CHECK;
               end else begin
                  tries <= tries + TRY_W'(1);
                  state <= last_try ? ST_FALLBK : ST_DRAW;
               end
            end
            ST_CHECK: begin
               if (OCC_ACK) begin
                  if (!OCC_HIT) begin
                     // Target, VALID and FALLBACK all commit on the edge into DONE.
                     TARGET_ADDR_H <= OCC_ADDR_H;
                     TARGET_ADDR_V <= OCC_ADDR_V;
                     FALLBACK      <= 1'b0;
                     VALID         <= 1'b1;
                     state         <= ST_DONE;
                  end else begin
                     tries <= tries + TRY_W'(1);
                     state <= last_try ? ST_FALLBK : ST_DRAW;
                  end
               end
            end
            ST_FALLBK: begin
               TARGET_ADDR_H <= CTR_H;
               TARGET_ADDR_V <= CTR_V;
               FALLBACK      <= 1'b1;
               VALID         <= 1'b1;
               state         <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign BUSY    = (state != ST_IDLE);
   assign OCC_REQ = (state == ST_CHECK);

endmodule
